// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store responder in front of a
// synchronous-read block RAM. It issues byte-enabled writes and
// sign/zero-extended reads, and holds the pipeline while an access is
// in flight. Misaligned or unsupported requests are flagged on
// Access_err and never reach the RAM.
module dmem_access_unit #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1    // 1..4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Mem_r,
  input  logic                  Mem_w,
  input  logic [2:0]            Funct3,
  input  logic [31:0]           Addr,
  input  logic [31:0]           Wdata,
  output logic [31:0]           Rdata,
  output logic                  Rdata_valid,
  output logic                  Mem_stall,
  output logic                  Access_err,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Two bits cover a wait of up to 4 cycles (counter starts at LAT-1).
  localparam int         CW       = 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

  // Load context captured at acceptance; the extension happens several
  // cycles later and must not depend on what upstream drives by then.
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] off;
  } ld_ctx_t;

  logic [2:0]    state, nxt_state;
  logic [CW-1:0] cnt;
  ld_ctx_t       ld_ctx;

  logic          is_store, is_load;
  logic          st_ok, ld_ok, aligned;
  logic          go_write, go_read, go_err;
  logic [3:0]    st_we;
  logic [31:0]   st_wdata;
  logic [31:0]   ld_ext;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [1:0]    off;

  // Upper address bits lie outside the attached RAM and are ignored.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:ADDR_WIDTH+2];

  assign off = Addr[1:0];

  // Request decode: store wins over load when both are raised.
  always_comb begin
    is_store = Mem_w;
    is_load  = Mem_r & ~Mem_w;
    st_ok    = (Funct3 == F3_B) || (Funct3 == F3_H) || (Funct3 == F3_W);
    ld_ok    = st_ok || (Funct3 == F3_BU) || (Funct3 == F3_HU);
    case (Funct3[1:0])
      2'b10:   aligned = (off == 2'b00);
      2'b01:   aligned = ~off[0];
      2'b00:   aligned = 1'b1;
      default: aligned = 1'b0;
    endcase
    go_write = is_store & st_ok & aligned;
    go_read  = is_load  & ld_ok & aligned;
    go_err   = (Mem_r | Mem_w) & ~go_write & ~go_read;
  end

  // Store lane placement: replicate the narrow datum, steer byte enables.
  always_comb begin
    st_we    = 4'b1111;
    st_wdata = Wdata;
    case (Funct3)
      F3_B: begin
        st_we    = 4'b0001 << off;
        st_wdata = {4{Wdata[7:0]}};
      end
      F3_H: begin
        st_we    = 4'b0011 << off;
        st_wdata = {2{Wdata[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = Wdata;
      end
    endcase
  end

  // Load lane selection and sign/zero extension of the returning word.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (ld_ctx.off)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = ld_ctx.off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_ctx.funct3)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_ext = {24'd0, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    nxt_state = S_IDLE;
    case (state)
      S_IDLE: begin
        if (go_write)      nxt_state = S_WRITE;
        else if (go_read)  nxt_state = S_READ;
        else if (go_err)   nxt_state = S_ERR;
        else               nxt_state = S_IDLE;
      end
      S_WRITE: nxt_state = S_IDLE;
      S_READ:  nxt_state = S_WAIT;
      S_WAIT:  nxt_state = (cnt == '0) ? S_DONE : S_WAIT;
      S_DONE:  nxt_state = S_IDLE;
      S_ERR:   nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Stall covers acceptance in IDLE plus the whole read round trip; a
  // store or error releases the pipeline as soon as it is accepted.
  always_comb begin
    case (state)
      S_IDLE:         Mem_stall = Mem_r | Mem_w;
      S_READ, S_WAIT: Mem_stall = 1'b1;
      default:        Mem_stall = 1'b0;
    endcase
  end

  // State, wait counter and registered outputs. The RAM port and the
  // pulses are loaded on the edge that enters WRITE/READ/DONE/ERR so they
  // are high exactly for that one state, and default back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ld_ctx      <= '0;
      Rdata       <= '0;
      Rdata_valid <= 1'b0;
      Access_err  <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= nxt_state;
      Rdata_valid <= 1'b0;
      Access_err  <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      case (state)
        S_IDLE: begin
          if (go_write) begin
            mem_en    <= 1'b1;
            mem_we    <= st_we;
            mem_addr  <= Addr[ADDR_WIDTH+1:2];
            mem_wdata <= st_wdata;
          end else if (go_read) begin
            mem_en    <= 1'b1;
            mem_addr  <= Addr[ADDR_WIDTH+1:2];
            ld_ctx    <= '{funct3: Funct3, off: off};
          end else if (go_err) begin
            Access_err <= 1'b1;
          end
        end
        S_READ: cnt <= CNT_INIT;
        S_WAIT: begin
          if (cnt == '0) begin
            Rdata       <= ld_ext;
            Rdata_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: two instances (read latency 1 and
// 3) share the request inputs; sel picks which one is being checked.
module tb_dmem_access_unit;

  localparam int AW = 10;
  localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

  logic          clk = 1'b0;
  logic          rst, rst3;
  logic          Mem_r, Mem_w;
  logic [2:0]    Funct3;
  logic [31:0]   Addr, Wdata, mem_rdata;

  logic [31:0]   rdata1, rdata3, wdata1, wdata3;
  logic          rv1, rv3, stall1, stall3, err1, err3, en1, en3;
  logic [3:0]    we1, we3;
  logic [AW-1:0] addr1, addr3;

  int  n_chk = 0;
  int  n_err = 0;
  bit  sel   = 1'b0;

  wire [31:0]   o_rdata = sel ? rdata3 : rdata1;
  wire          o_rv    = sel ? rv3    : rv1;
  wire          o_stall = sel ? stall3 : stall1;
  wire          o_err   = sel ? err3   : err1;
  wire          o_en    = sel ? en3    : en1;
  wire [3:0]    o_we    = sel ? we3    : we1;
  wire [AW-1:0] o_addr  = sel ? addr3  : addr1;
  wire [31:0]   o_wdata = sel ? wdata3 : wdata1;

  always #5 clk = ~clk;

  dmem_access_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .Mem_r(Mem_r), .Mem_w(Mem_w), .Funct3(Funct3),
    .Addr(Addr), .Wdata(Wdata), .Rdata(rdata1), .Rdata_valid(rv1),
    .Mem_stall(stall1), .Access_err(err1), .mem_en(en1), .mem_we(we1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(mem_rdata)
  );

  dmem_access_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst3), .Mem_r(Mem_r), .Mem_w(Mem_w), .Funct3(Funct3),
    .Addr(Addr), .Wdata(Wdata), .Rdata(rdata3), .Rdata_valid(rv3),
    .Mem_stall(stall3), .Access_err(err3), .mem_en(en3), .mem_we(we3),
    .mem_addr(addr3), .mem_wdata(wdata3), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    Mem_r = r; Mem_w = w; Funct3 = f3; Addr = a; Wdata = wd;
  endtask

  task automatic clr_req;
    Mem_r = 1'b0; Mem_w = 1'b0; Funct3 = 3'd0; Addr = 32'd0; Wdata = 32'd0;
  endtask

  task automatic do_store(input string nm, input logic r, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] x_we, input logic [31:0] x_wd,
                          input logic [31:0] x_addr, input logic [31:0] x_rdata);
    cyc; set_req(r, 1'b1, f3, a, wd);
    @(negedge clk);
    check({nm, " idle stall"}, o_stall, 1);
    check({nm, " idle en"},    o_en, 0);
    cyc; clr_req;
    @(negedge clk);
    check({nm, " wr en"},    o_en, 1);
    check({nm, " wr we"},    o_we, x_we);
    check({nm, " wr addr"},  o_addr, x_addr);
    check({nm, " wr wdata"}, o_wdata, x_wd);
    check({nm, " wr stall"}, o_stall, 0);
    check({nm, " wr rv"},    o_rv, 0);
    cyc;
    @(negedge clk);
    check({nm, " post en"},    o_en, 0);
    check({nm, " post we"},    o_we, 0);
    check({nm, " post rv"},    o_rv, 0);
    check({nm, " post rdata"}, o_rdata, x_rdata);
  endtask

  // RAM data is only presented in the cycle it is due; JUNK otherwise.
  task automatic do_load(input string nm, input int lat, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] x_addr, input logic [31:0] x_rdata);
    cyc; set_req(1'b1, 1'b0, f3, a, 32'd0); mem_rdata = JUNK;
    @(negedge clk);
    check({nm, " idle stall"}, o_stall, 1);
    cyc;
    @(negedge clk);
    check({nm, " rd stall"}, o_stall, 1);
    check({nm, " rd en"},    o_en, 1);
    check({nm, " rd we"},    o_we, 0);
    check({nm, " rd addr"},  o_addr, x_addr);
    for (int i = 0; i < lat; i++) begin
      cyc; mem_rdata = (i == lat - 1) ? rd : JUNK;
      @(negedge clk);
      check({nm, " wait stall"}, o_stall, 1);
      check({nm, " wait en"},    o_en, 0);
      check({nm, " wait rv"},    o_rv, 0);
    end
    cyc; clr_req; mem_rdata = JUNK;
    @(negedge clk);
    check({nm, " done rv"},    o_rv, 1);
    check({nm, " done rdata"}, o_rdata, x_rdata);
    check({nm, " done stall"}, o_stall, 0);
    cyc;
    @(negedge clk);
    check({nm, " post rv"},    o_rv, 0);
    check({nm, " post rdata"}, o_rdata, x_rdata);
  endtask

  task automatic do_err(input string nm, input logic r, input logic w,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] x_rdata);
    cyc; set_req(r, w, f3, a, 32'h1111_1111);
    @(negedge clk);
    check({nm, " idle stall"}, o_stall, 1);
    cyc; clr_req;
    @(negedge clk);
    check({nm, " err pulse"}, o_err, 1);
    check({nm, " err en"},    o_en, 0);
    check({nm, " err stall"}, o_stall, 0);
    check({nm, " err rdata"}, o_rdata, x_rdata);
    cyc;
    @(negedge clk);
    check({nm, " post err"}, o_err, 0);
    check({nm, " post en"},  o_en, 0);
    check({nm, " post rv"},  o_rv, 0);
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1; mem_rdata = JUNK;
    clr_req;
    repeat (3) cyc;
    @(negedge clk);
    check("rst rdata", o_rdata, 0);
    check("rst rv",    o_rv, 0);
    check("rst stall", o_stall, 0);
    check("rst err",   o_err, 0);
    check("rst en",    o_en, 0);
    check("rst we",    o_we, 0);
    check("rst addr",  o_addr, 0);
    check("rst wdata", o_wdata, 0);
    cyc; rst = 1'b0;

    // Stores on the latency-1 instance.
    do_store("SW", 1'b0, 3'b010, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 4, 0);
    do_store("SB", 1'b0, 3'b000, 32'h22, 32'h1234_56AB, 4'b0100, 32'hABAB_ABAB, 8, 0);
    do_store("SH", 1'b0, 3'b001, 32'h12, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 4, 0);

    // Loads with extension.
    do_load("LB",  1, 3'b000, 32'h13, 32'h80FF_7F01, 4, 32'hFFFF_FF80);
    do_load("LBU", 1, 3'b100, 32'h13, 32'h80FF_7F01, 4, 32'h0000_0080);
    do_load("LHU", 1, 3'b101, 32'h12, 32'h80FF_7F01, 4, 32'h0000_80FF);
    do_load("LBU1",1, 3'b100, 32'h11, 32'h80FF_7F01, 4, 32'h0000_007F);
    do_load("LH",  1, 3'b001, 32'h12, 32'h80FF_7F01, 4, 32'hFFFF_80FF);

    // Errors leave Rdata untouched.
    do_err("LWmis",  1'b1, 1'b0, 3'b010, 32'h06, 32'hFFFF_80FF);
    do_err("SHmis",  1'b0, 1'b1, 3'b001, 32'h21, 32'hFFFF_80FF);
    do_err("ST011",  1'b0, 1'b1, 3'b011, 32'h20, 32'hFFFF_80FF);
    do_err("LD110",  1'b1, 1'b0, 3'b110, 32'h20, 32'hFFFF_80FF);

    // Read and write together: store wins, no read, no Rdata_valid.
    do_store("RW", 1'b1, 3'b010, 32'h0, 32'h5, 4'b1111, 32'h5, 0, 32'hFFFF_80FF);

    // Latency-3 instance: normal load, aborted load, fresh load.
    sel = 1'b1;
    cyc; rst3 = 1'b0;
    do_load("LW3", 3, 3'b010, 32'h08, 32'h1122_3344, 2, 32'h1122_3344);
    cyc; set_req(1'b1, 1'b0, 3'b010, 32'h0C, 32'd0); mem_rdata = JUNK;
    @(negedge clk);
    check("abort idle stall", o_stall, 1);
    cyc;
    @(negedge clk);
    check("abort rd en", o_en, 1);
    cyc;
    @(negedge clk);
    check("abort wait1 stall", o_stall, 1);
    cyc; rst3 = 1'b1;
    @(negedge clk);
    check("abort wait2 stall", o_stall, 1);
    cyc; rst3 = 1'b0; clr_req;
    @(negedge clk);
    check("abort stall", o_stall, 0);
    check("abort rdata", o_rdata, 0);
    check("abort rv",    o_rv, 0);
    check("abort en",    o_en, 0);
    cyc;
    @(negedge clk);
    check("abort post rv", o_rv, 0);
    do_load("LW3b", 3, 3'b010, 32'h0C, 32'hCAFE_F00D, 3, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
